chain_mac_stage: RTL and testbench

//  Upstream feeder stage of the ena-handshaked stage chain. Consumes 14-bit operand pairs (x,y) from the

---
 rtl/chain_pkg.sv | 14 +
 rtl/chain_out_reg.sv | 38 +++
 rtl/chain_mac_stage.sv | 110 +++++++++++
 tb/tb_chain_mac_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/chain_pkg.sv
// Shared types and default widths for the ena-handshaked stage chain.
package chain_pkg;
  localparam int DEF_OPW  = 14;
  localparam int DEF_ACCW = 50;
  localparam int DEF_CNTW = 16;

  typedef enum logic {IDLE, ACCUM} acc_state_t;

  typedef struct packed {
    logic [DEF_ACCW-1:0] data;
    logic [DEF_CNTW-1:0] cnt;
    logic                ovf;
  } chain_result_t;
endpackage

// File: rtl/chain_out_reg.sv
// One-entry valid/ready holding register; a load in the same cycle as a drain wins.
module chain_out_reg import chain_pkg::*; #(
  parameter type T = chain_result_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  T     load_data,
  input  logic out_rdy,
  output logic out_vld,
  output T     out_data
);
  logic vld_q, vld_d;
  T     data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (vld_q && out_rdy) vld_d = 1'b0;
    if (load) begin
      vld_d  = 1'b1;
      data_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = data_q;
endmodule

// File: rtl/chain_mac_stage.sv
// Feeder stage: accumulates x*y per z-terminated group and hands one sum per group
// to an output register, so accumulation of the next group is not blocked by back-pressure.
module chain_mac_stage import chain_pkg::*; #(
  parameter int OPW  = DEF_OPW,
  parameter int ACCW = DEF_ACCW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prev_ena,
  input  logic [OPW-1:0]  prev_x,
  input  logic [OPW-1:0]  prev_y,
  input  logic            prev_z,
  output logic            prev_rdy,
  output logic            next_ena,
  output logic [ACCW-1:0] next_data,
  output logic [CNTW-1:0] next_cnt,
  output logic            next_ovf,
  input  logic            next_rdy
);
  typedef struct packed {
    logic [ACCW-1:0] data;
    logic [CNTW-1:0] cnt;
    logic            ovf;
  } result_t;

  acc_state_t      state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d, acc_base;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
  logic            ovf_q, ovf_d, ovf_base;
  logic [2*OPW-1:0] prod;
  logic [ACCW:0]   sum;
  logic            beat, load;
  result_t         load_res, out_res;

  // Only a last beat can collide with an unconsumed result.
  assign prev_rdy = !prev_z || !next_ena || next_rdy;
  assign beat     = prev_ena && prev_rdy;
  assign prod     = (2*OPW)'(prev_x) * (2*OPW)'(prev_y);

  always_comb begin
    acc_base = (state_q == ACCUM) ? acc_q : '0;
    cnt_base = (state_q == ACCUM) ? cnt_q : '0;
    ovf_base = (state_q == ACCUM) ? ovf_q : 1'b0;
    sum      = {1'b0, acc_base} + (ACCW+1)'(prod);
    cnt_inc  = (cnt_base == {CNTW{1'b1}}) ? cnt_base : cnt_base + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat && !prev_z) state_d = ACCUM;
      ACCUM:   if (beat &&  prev_z) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    load          = 1'b0;
    load_res.data = sum[ACCW-1:0];
    load_res.cnt  = cnt_inc;
    load_res.ovf  = ovf_base | sum[ACCW];
    if (beat) begin
      if (prev_z) begin
        load  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum[ACCW-1:0];
        cnt_d = cnt_inc;
        ovf_d = ovf_base | sum[ACCW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  chain_out_reg #(.T(result_t)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_res),
    .out_rdy   (next_rdy),
    .out_vld   (next_ena),
    .out_data  (out_res)
  );

  assign next_data = out_res.data;
  assign next_cnt  = out_res.cnt;
  assign next_ovf  = out_res.ovf;
endmodule

// File: tb/tb_chain_mac_stage.sv
// Bench for chain_mac_stage: three builds (default, ACCW=28, CNTW=2) share one stimulus stream
// and are checked every cycle against a group-sum model plus hand-computed expectations.
module tb_chain_mac_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prev_ena = 1'b0, prev_z = 1'b0, next_rdy = 1'b1;
  logic [13:0] prev_x = '0, prev_y = '0;

  logic        rdy0, rdy1, rdy2, ena0, ena1, ena2, ovf0, ovf1, ovf2;
  logic [49:0] data0, data2;
  logic [27:0] data1;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  chain_mac_stage u_dut0 (
    .clk(clk), .rst_n(rst_n), .prev_ena(prev_ena), .prev_x(prev_x), .prev_y(prev_y),
    .prev_z(prev_z), .prev_rdy(rdy0), .next_ena(ena0), .next_data(data0), .next_cnt(cnt0),
    .next_ovf(ovf0), .next_rdy(next_rdy));
  chain_mac_stage #(.ACCW(28)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .prev_ena(prev_ena), .prev_x(prev_x), .prev_y(prev_y),
    .prev_z(prev_z), .prev_rdy(rdy1), .next_ena(ena1), .next_data(data1), .next_cnt(cnt1),
    .next_ovf(ovf1), .next_rdy(next_rdy));
  chain_mac_stage #(.CNTW(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .prev_ena(prev_ena), .prev_x(prev_x), .prev_y(prev_y),
    .prev_z(prev_z), .prev_rdy(rdy2), .next_ena(ena2), .next_data(data2), .next_cnt(cnt2),
    .next_ovf(ovf2), .next_rdy(next_rdy));

  function automatic int accw_of(int i);
    return (i == 1) ? 28 : 50;
  endfunction
  function automatic int cntw_of(int i);
    return (i == 2) ? 2 : 16;
  endfunction

  // Model: true group sum and beat count; wrap, overflow and saturation derived from them.
  longint unsigned g_sum[3], m_data[3], m_cnt[3];
  int              g_n[3];
  bit              m_vld[3], m_ovf[3];
  bit              started = 1'b0;

  always @(posedge clk) begin
    bit rdy;
    longint unsigned cmax;
    if (!rst_n) started = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        g_sum[i] = 0; g_n[i] = 0; m_vld[i] = 0; m_data[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      end else begin
        rdy = !prev_z || !m_vld[i] || next_rdy;
        if (m_vld[i] && next_rdy) m_vld[i] = 1'b0;
        if (prev_ena && rdy) begin
          g_sum[i] += 64'(prev_x) * 64'(prev_y);
          g_n[i]++;
          if (prev_z) begin
            cmax      = (64'd1 << cntw_of(i)) - 1;
            m_vld[i]  = 1'b1;
            m_data[i] = g_sum[i] & ((64'd1 << accw_of(i)) - 1);
            m_cnt[i]  = (64'(g_n[i]) > cmax) ? cmax : 64'(g_n[i]);
            m_ovf[i]  = (g_sum[i] >> accw_of(i)) != 0;
            g_sum[i]  = 0;
            g_n[i]    = 0;
          end
        end
      end
    end
  end

  typedef struct {
    int              at;
    int              inst;
    string           name;
    bit              flds;
    bit              rdy_chk;
    logic            ena;
    longint unsigned data;
    longint unsigned cnt;
    logic            ovf;
    logic            rdy;
  } lit_t;

  lit_t lit;
  int   cyc = 0;
  int   checks = 0, errs = 0;
  bit   tmo = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] ad[3], ac[3];
    logic        ae[3], ao[3], ar[3];
    int          k;
    cyc++;
    ad = '{64'(data0), 64'(data1), 64'(data2)};
    ac = '{64'(cnt0), 64'(cnt1), 64'(cnt2)};
    ae = '{ena0, ena1, ena2};
    ao = '{ovf0, ovf1, ovf2};
    ar = '{rdy0, rdy1, rdy2};
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ena%0d", i), 64'(ae[i]), 64'(m_vld[i]));
        chk($sformatf("prev_rdy%0d", i), 64'(ar[i]), 64'(!prev_z || !m_vld[i] || next_rdy));
        if (m_vld[i]) begin
          chk($sformatf("data%0d", i), ad[i], m_data[i]);
          chk($sformatf("cnt%0d", i), ac[i], m_cnt[i]);
          chk($sformatf("ovf%0d", i), 64'(ao[i]), 64'(m_ovf[i]));
        end
      end
    end
    chk("timeout", 64'(tmo), 64'd0);
    if (lit.at == cyc) begin
      k = lit.inst;
      chk({lit.name, "_ena"}, 64'(ae[k]), 64'(lit.ena));
      if (lit.flds) begin
        chk({lit.name, "_data"}, ad[k], lit.data);
        chk({lit.name, "_cnt"}, ac[k], lit.cnt);
        chk({lit.name, "_ovf"}, 64'(ao[k]), 64'(lit.ovf));
      end
      if (lit.rdy_chk) chk({lit.name, "_rdy"}, 64'(ar[k]), 64'(lit.rdy));
    end
  end

  // Expectation for the next falling edge.
  task automatic post(input int inst, input string name, input bit flds, input logic ena,
                      input longint unsigned data, input longint unsigned cnt, input logic ovf,
                      input bit rdy_chk, input logic rdy);
    lit.at = cyc + 1; lit.inst = inst; lit.name = name; lit.flds = flds; lit.ena = ena;
    lit.data = data; lit.cnt = cnt; lit.ovf = ovf; lit.rdy_chk = rdy_chk; lit.rdy = rdy;
  endtask

  task automatic beat(input logic [13:0] x, input logic [13:0] y, input logic z);
    int n = 0;
    @(negedge clk); #1;
    prev_ena = 1'b1; prev_x = x; prev_y = y; prev_z = z;
    #1;
    while (!rdy0 && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 20) tmo = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk); #1;
    prev_ena = 1'b0; prev_z = 1'b0;
  endtask

  initial begin
    lit.at = -1; lit.inst = 0; lit.name = ""; lit.flds = 0; lit.rdy_chk = 0;
    lit.ena = 0; lit.data = 0; lit.cnt = 0; lit.ovf = 0; lit.rdy = 0;
    @(negedge clk); #1;
    post(0, "reset", 1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // 1: three-beat group
    beat(2, 3, 0); beat(4, 5, 0); beat(1, 1, 1);
    post(0, "grp3", 1, 1'b1, 27, 3, 1'b0, 0, 1'b0);
    idle();
    post(0, "grp3_drop", 0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    idle();

    // 2: back-to-back single-beat groups
    beat(16383, 16383, 1);
    post(0, "single_a", 1, 1'b1, 268402689, 1, 1'b0, 1, 1'b1);
    beat(16383, 16383, 1);
    post(0, "single_b", 1, 1'b1, 268402689, 1, 1'b0, 1, 1'b1);
    idle();
    idle();

    // 3: last beat stalls behind an unconsumed result
    next_rdy = 1'b0;
    beat(2, 2, 1);
    post(0, "pend", 1, 1'b1, 4, 1, 1'b0, 0, 1'b0);
    repeat (4) beat(1, 1, 0);
    @(negedge clk); #1;
    prev_ena = 1'b1; prev_x = 1; prev_y = 1; prev_z = 1'b1;
    post(0, "stall", 1, 1'b1, 4, 1, 1'b0, 1, 1'b0);
    @(negedge clk); #1;
    post(0, "stall_hold", 1, 1'b1, 4, 1, 1'b0, 1, 1'b0);
    @(negedge clk); #1;
    next_rdy = 1'b1;
    @(posedge clk); #1;
    post(0, "drain_load", 1, 1'b1, 5, 5, 1'b0, 1, 1'b1);
    idle();
    idle();

    // 4: overflow on the ACCW=28 build
    beat(16383, 16383, 0); beat(16383, 16383, 0); beat(0, 0, 1);
    post(1, "ovf28", 1, 1'b1, 268369922, 3, 1'b1, 0, 1'b0);
    idle();
    idle();

    // 5: reset mid-group with a result pending
    next_rdy = 1'b0;
    beat(2, 3, 1);
    beat(1, 2, 0); beat(3, 4, 0);
    @(negedge clk); #1;
    rst_n = 1'b0; prev_ena = 1'b0;
    @(posedge clk); #1;
    post(0, "rst_mid", 1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1; next_rdy = 1'b1;
    beat(3, 3, 1);
    post(0, "after_rst", 1, 1'b1, 9, 1, 1'b0, 0, 1'b0);
    idle();

    // 6: count saturation on the CNTW=2 build
    repeat (4) beat(1, 1, 0);
    beat(1, 1, 1);
    post(2, "sat", 1, 1'b1, 5, 3, 1'b0, 0, 1'b0);
    idle();

    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
